ik_swift_hps_st_packet_arbiter: RTL and testbench
=================================================

// Module: ik_swift_hps_st_packet_arbiter
// PURPOSE
//  Packet-level round-robin arbiter merging NUM_IN Avalon-ST byte streams into one channelized stream.
//  Sits upstream of the bytes-to-packets channel adapter and drives its in_* port.
//  The granted input's index is carried on out_channel. A grant is held from SOP through EOP.
//  The output stage is registered.
// PARAMETERS
//  NUM_IN     4   number of requesting input streams (2..8)
//  CHANNEL_W  8   out_channel width; index is zero-extended
// PORTS
//  clk                input   1            system clock
//  reset_n            input   1            asynchronous active-low reset
//  in_valid           input   NUM_IN       per-input beat valid
//  in_ready           output  NUM_IN       per-input ready (one-hot or zero)
//  in_data            input   8*NUM_IN     per-input byte, input i at [8i+7:8i]
//  in_startofpacket   input   NUM_IN       per-input SOP
//  in_endofpacket     input   NUM_IN       per-input EOP
//  out_ready          input   1            downstream ready
//  out_valid          output  1            output beat valid (registered)
//  out_data           output  8            output byte
//  out_channel        output  CHANNEL_W    index of the source input
//  out_startofpacket  output  1            output SOP
//  out_endofpacket    output  1            output EOP
//  sop_err            output  1            sticky flag: a non-SOP first beat was dropped
// BEHAVIOUR
//  Reset
//   - Async assert: state=IDLE, rr_ptr=0, grant=0, sop_err=0.
//   - All out_* = 0; in_ready = 0.
//   - Reset mid-packet truncates the packet; no EOP is emitted.
//  Transfer rules
//   - Input beat accepted: in_valid[i] & in_ready[i].
//   - Output beat accepted: out_valid & out_ready.
//   - can_load = !out_valid | out_ready.
//  FSM IDLE
//   - in_ready = 0.
//   - If any in_valid: grant = first set bit searching rr_ptr, rr_ptr+1, ... (mod NUM_IN).
//   - Go to FIRST next cycle. Arbitration costs one cycle.
//  FSM FIRST
//   - in_ready[grant] = can_load.
//   - Accepted beat with SOP=1: load into output register. If EOP=1 (single-beat packet), go to IDLE; else go to PKT.
//   - Accepted beat with SOP=0: discard it, set sop_err, stay in FIRST.
//  FSM PKT
//   - in_ready[grant] = can_load.
//   - Each accepted beat loads the output register.
//   - A beat with SOP=1 mid-packet is forwarded unchanged (no check).
//   - Accepted EOP beat: go to IDLE, rr_ptr = (grant+1) mod NUM_IN.
//   - The FIRST EOP case updates rr_ptr the same way.
//  Output register
//   - Load sets out_valid=1 and captures data/sop/eop; out_channel = grant.
//   - No load and out_ready: out_valid=0. Data fields hold their last values.
//   - Load and drain in the same cycle: the new beat replaces the old one; no bubble.
//  Timing
//   - Latency from an in-transfer to out_valid is 1 cycle.
//   - Request in IDLE to first out_valid is 2 cycles minimum.
//   - Full throughput (1 beat/clk) inside a packet while out_ready=1.
//   - Inter-packet gap is 1 idle cycle (the IDLE arbitration cycle).
//  Boundaries
//   - The granted input may deassert in_valid mid-packet; the grant is held indefinitely.
//   - Non-granted inputs always see in_ready=0.
//   - out_ready=0 with out_valid=1: in_ready=0 and the output is stable (Avalon-ST hold).
//   - rr_ptr wraps from NUM_IN-1 to 0.
//   - All inputs requesting: service order is strict rotation.
// TESTING
//  1. Single request: in0 sends a 3-byte packet A1,A2,A3 with out_ready=1.
//     -> out beats A1(sop),A2,A3(eop), channel 0, out_valid first high 2 cycles after in_valid.
//  2. Fairness: all 4 inputs send 2-beat packets continuously.
//     -> out_channel sequence 0,1,2,3,0; never interleaved within a packet.
//  3. Backpressure: out_ready toggles 1,0,0,1 during a packet from in2.
//     -> no beat lost or duplicated; out_data stable while out_ready=0.
//  4. Bad start: in1 sends first beat 0x55 with sop=0, then 0x66 sop=1,eop=1.
//     -> sop_err=1; single output beat 0x66, sop=1, eop=1, channel 1.
//  5. Reset mid-packet: assert reset_n=0 after 2 beats of a 5-beat packet.
//     -> out_valid=0 and in_ready=0 immediately; after release, in3 alone is granted; rr_ptr=0 search order.
//  6. Wrap: rr_ptr=3, only in3 and in0 request.
//     -> in3 is served, then in0.

Source files
------------

// File: rtl/ik_swift_hps_st_packet_arbiter.sv
// Packet-level round-robin arbiter: merges NUM_IN Avalon-ST byte streams into
// one channelized stream. A grant is held from SOP through EOP, the winner's
// index rides on out_channel, and the output stage is a single register that
// sustains one beat per clock while downstream is ready.
module ik_swift_hps_st_packet_arbiter #(
  parameter int NUM_IN    = 4,
  parameter int CHANNEL_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_IN-1:0]     in_valid,
  output logic [NUM_IN-1:0]     in_ready,
  input  logic [8*NUM_IN-1:0]   in_data,
  input  logic [NUM_IN-1:0]     in_startofpacket,
  input  logic [NUM_IN-1:0]     in_endofpacket,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  output logic [CHANNEL_W-1:0]  out_channel,
  output logic                  out_startofpacket,
  output logic                  out_endofpacket,
  output logic                  sop_err
);

  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    PKT   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]  grant, grant_nxt;
  logic [IDX_W-1:0]  pick;
  logic [IDX_W-1:0]  ptr_after_grant;
  logic              pick_found;
  logic              can_load;
  logic              load;
  logic              sop_err_set;
  logic              sel_valid, sel_sop, sel_eop;
  logic [7:0]        sel_data;
  int                idx;

  // The output register can take a new beat when empty or draining this cycle.
  assign can_load = !out_valid || out_ready;

  // Fields of the currently granted input.
  assign sel_valid = in_valid[grant];
  assign sel_sop   = in_startofpacket[grant];
  assign sel_eop   = in_endofpacket[grant];
  assign sel_data  = in_data[8*grant +: 8];

  // Pointer value after the granted packet completes, wrapping NUM_IN-1 -> 0.
  assign ptr_after_grant = (int'(grant) == NUM_IN - 1) ? '0 : grant + 1'b1;

  // Round-robin search: first requesting input at rr_ptr, rr_ptr+1, ... mod NUM_IN.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    idx        = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_IN;
      if (!pick_found && in_valid[idx]) begin
        pick       = IDX_W'(idx);
        pick_found = 1'b1;
      end
    end
  end

  // Next-state, grant/pointer update and per-input ready generation.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt   = state;
    grant_nxt   = grant;
    rr_ptr_nxt  = rr_ptr;
    in_ready    = '0;
    load        = 1'b0;
    sop_err_set = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_nxt = pick;
          state_nxt = FIRST;
        end
      end
      FIRST: begin
        in_ready[grant] = can_load;
        if (sel_valid && can_load) begin
          if (sel_sop) begin
            load = 1'b1;
            if (sel_eop) begin
              state_nxt  = IDLE;
              rr_ptr_nxt = ptr_after_grant;
            end else begin
              state_nxt = PKT;
            end
          end else begin
            // A packet must open with SOP; stray beats are dropped and flagged.
            sop_err_set = 1'b1;
          end
        end
      end
      PKT: begin
        in_ready[grant] = can_load;
        if (sel_valid && can_load) begin
          load = 1'b1;
          if (sel_eop) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = ptr_after_grant;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Arbitration state registers and the sticky SOP error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      grant   <= '0;
      sop_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      grant  <= grant_nxt;
      if (sop_err_set) sop_err <= 1'b1;
    end
  end

  // Output register: load replaces the held beat, an idle drain clears valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_channel       <= '0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
    end else if (load) begin
      out_valid         <= 1'b1;
      out_data          <= sel_data;
      out_channel       <= CHANNEL_W'(grant);
      out_startofpacket <= sel_sop;
      out_endofpacket   <= sel_eop;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ik_swift_hps_st_packet_arbiter.sv
// Self-checking bench for the packet arbiter: per-input packet queues feed the
// DUT, and a per-channel scoreboard of the packets each input should deliver
// (stray pre-SOP beats removed) checks every output beat, packet order and
// Avalon-ST hold behaviour.
module tb_ik_swift_hps_st_packet_arbiter;

  localparam int N  = 4;
  localparam int CW = 8;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } beat_t;

  logic              clk;
  logic              reset_n;
  logic [N-1:0]      in_valid;
  logic [N-1:0]      in_ready;
  logic [8*N-1:0]    in_data;
  logic [N-1:0]      in_startofpacket;
  logic [N-1:0]      in_endofpacket;
  logic              out_ready;
  logic              out_valid;
  logic [7:0]        out_data;
  logic [CW-1:0]     out_channel;
  logic              out_startofpacket;
  logic              out_endofpacket;
  logic              sop_err;

  ik_swift_hps_st_packet_arbiter #(.NUM_IN(N), .CHANNEL_W(CW)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_channel       (out_channel),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .sop_err           (sop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state
  beat_t src_q[N][$];   // beats each input will present, in order
  beat_t exp_q[N][$];   // beats each input should deliver downstream
  int    pkt_order[$];  // channels of output packets, in order of SOP
  bit    ready_pat[$];  // optional scripted out_ready values
  int    tests, fails;
  int    cyc;
  int    vprob, rprob;
  logic [N-1:0] acc;
  bit    in_pkt;
  int    cur_ch;
  bit    prev_hold;
  beat_t hold_beat;
  logic [CW-1:0] hold_ch;
  int    out_beats;
  int    first_out_cyc, last_out_cyc;
  bit    exp_sop_err;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit all_empty();
    for (int i = 0; i < N; i++)
      if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
    return !in_pkt;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    pkt_order.delete();
    ready_pat.delete();
    in_valid         = '0;
    in_data          = '0;
    in_startofpacket = '0;
    in_endofpacket   = '0;
    acc              = '0;
    in_pkt           = 1'b0;
    cur_ch           = 0;
    prev_hold        = 1'b0;
    out_beats        = 0;
    first_out_cyc    = -1;
    last_out_cyc     = -1;
    cyc              = 0;
    exp_sop_err      = 1'b0;
  endtask

  task automatic reset_release();
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    out_ready = 1'b1;
    clear_model();
    vprob = 100;
    rprob = 100;
    repeat (2) @(posedge clk);
    reset_release();
  endtask

  task automatic add_stray(input int i, input logic [7:0] d, input logic e);
    beat_t b;
    b = '{data: d, sop: 1'b0, eop: e};
    src_q[i].push_back(b);
    exp_sop_err = 1'b1;
  endtask

  task automatic add_packet(input int i, input int len, input logic [7:0] base);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b = '{data: base + 8'(k), sop: (k == 0), eop: (k == len - 1)};
      src_q[i].push_back(b);
      exp_q[i].push_back(b);
    end
  endtask

  // Pop beats accepted last cycle, then present the next beats and out_ready.
  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (acc[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
      if (src_q[i].size() != 0 && int'($urandom_range(99)) < vprob) begin
        in_valid[i]         = 1'b1;
        in_data[8*i +: 8]   = src_q[i][0].data;
        in_startofpacket[i] = src_q[i][0].sop;
        in_endofpacket[i]   = src_q[i][0].eop;
      end else begin
        in_valid[i]         = 1'b0;
        in_data[8*i +: 8]   = 8'($urandom);
        in_startofpacket[i] = 1'b0;
        in_endofpacket[i]   = 1'b0;
      end
    end
    if (ready_pat.size() != 0) out_ready = ready_pat.pop_front();
    else out_ready = (int'($urandom_range(99)) < rprob);
  endtask

  // Mid-cycle observation of handshakes, hold rules and the output scoreboard.
  task automatic monitor();
    beat_t got, exp;
    int ch;
    acc = in_valid & in_ready;
    tests++;
    if ($countones(in_ready) > 1) begin
      fails++;
      $display("FAIL ready_onehot cyc=%0d in_ready=%b required at most one bit", cyc, in_ready);
    end
    if (out_valid && !out_ready) begin
      tests++;
      if (in_ready !== '0) begin
        fails++;
        $display("FAIL ready_under_hold cyc=%0d in_ready=%b required 0", cyc, in_ready);
      end
    end
    got = '{data: out_data, sop: out_startofpacket, eop: out_endofpacket};
    if (prev_hold) begin
      tests++;
      if (out_valid !== 1'b1 || got !== hold_beat || out_channel !== hold_ch) begin
        fails++;
        $display("FAIL output_hold cyc=%0d got v=%b %h/%0d required v=1 %h/%0d",
                 cyc, out_valid, got, out_channel, hold_beat, hold_ch);
      end
    end
    prev_hold = out_valid && !out_ready;
    hold_beat = got;
    hold_ch   = out_channel;
    if (out_valid && out_ready) begin
      ch = int'(out_channel);
      tests++;
      if (ch >= N) begin
        fails++;
        $display("FAIL channel_range cyc=%0d channel=%0d required <%0d", cyc, ch, N);
      end else if (in_pkt && ch != cur_ch) begin
        fails++;
        $display("FAIL interleave cyc=%0d channel=%0d required %0d", cyc, ch, cur_ch);
      end else if (!in_pkt && !out_startofpacket) begin
        fails++;
        $display("FAIL missing_sop cyc=%0d beat=%h required sop=1", cyc, got);
      end else if (exp_q[ch].size() == 0) begin
        fails++;
        $display("FAIL unexpected_beat cyc=%0d channel=%0d beat=%h required none", cyc, ch, got);
      end else begin
        exp = exp_q[ch].pop_front();
        if (got !== exp) begin
          fails++;
          $display("FAIL beat_data cyc=%0d channel=%0d got %h required %h", cyc, ch, got, exp);
        end
      end
      if (out_startofpacket && !in_pkt) pkt_order.push_back(ch);
      in_pkt = !out_endofpacket;
      cur_ch = ch;
      out_beats++;
      if (first_out_cyc < 0) first_out_cyc = cyc;
      last_out_cyc = cyc;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1 drive_inputs();
    @(negedge clk);
    monitor();
    cyc++;
  endtask

  task automatic run(input int budget, input string name);
    int n;
    n = 0;
    while (!all_empty() && n < budget) begin
      step();
      n++;
    end
    if (!all_empty()) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout after %0d cycles, traffic still pending", name, n);
    end
    in_valid = '0;
  endtask

  task automatic check_order(input string name, input int exp_ord[$]);
    tests++;
    if (pkt_order != exp_ord) begin
      fails++;
      $display("FAIL %s_order got %p required %p", name, pkt_order, exp_ord);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_model();
    out_ready = 1'b1;
    in_valid  = '1;
    #1;
    tests++;
    if ({out_valid, out_data, out_channel, out_startofpacket, out_endofpacket, sop_err} !== '0
        || in_ready !== '0) begin
      fails++;
      $display("FAIL reset_state v=%b d=%h ch=%h sop=%b eop=%b err=%b rdy=%b required all 0",
               out_valid, out_data, out_channel, out_startofpacket, out_endofpacket,
               sop_err, in_ready);
    end
    in_valid = '0;
    reset_release();
  endtask

  task automatic test_single();
    do_reset();
    add_packet(0, 3, 8'hA1);
    run(50, "single");
    check_order("single", '{0});
    tests++;
    if (first_out_cyc != 2 || last_out_cyc != 4 || out_beats != 3) begin
      fails++;
      $display("FAIL single_timing first=%0d last=%0d beats=%0d required 2 4 3",
               first_out_cyc, last_out_cyc, out_beats);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) add_packet(i, 2, 8'(16 * i + 2 * r));
    run(100, "fairness");
    check_order("fairness", '{0, 1, 2, 3, 0, 1, 2, 3});
    tests++;
    if (last_out_cyc != 24) begin
      fails++;
      $display("FAIL fairness_throughput last_beat_cycle=%0d required 24", last_out_cyc);
    end
  endtask

  task automatic test_back_to_back_backpressure();
    do_reset();
    add_packet(2, 6, 8'hC0);
    repeat (4) begin
      ready_pat.push_back(1'b1);
      ready_pat.push_back(1'b0);
      ready_pat.push_back(1'b0);
      ready_pat.push_back(1'b1);
    end
    run(100, "backpressure");
    check_order("backpressure", '{2});
    tests++;
    if (out_beats != 6) begin
      fails++;
      $display("FAIL backpressure_beats got %0d required 6", out_beats);
    end
  endtask

  task automatic test_mid_sop();
    do_reset();
    src_q[0].push_back('{data: 8'h10, sop: 1'b1, eop: 1'b0});
    src_q[0].push_back('{data: 8'h11, sop: 1'b1, eop: 1'b0});
    src_q[0].push_back('{data: 8'h12, sop: 1'b0, eop: 1'b1});
    exp_q[0] = src_q[0];
    run(50, "mid_sop");
    check_order("mid_sop", '{0});
  endtask

  task automatic test_bad_start();
    do_reset();
    tests++;
    if (sop_err !== 1'b0) begin
      fails++;
      $display("FAIL bad_start_pre sop_err=%b required 0", sop_err);
    end
    add_stray(1, 8'h55, 1'b0);
    src_q[1].push_back('{data: 8'h66, sop: 1'b1, eop: 1'b1});
    exp_q[1].push_back('{data: 8'h66, sop: 1'b1, eop: 1'b1});
    run(50, "bad_start");
    check_order("bad_start", '{1});
    tests++;
    if (sop_err !== 1'b1 || out_beats != 1) begin
      fails++;
      $display("FAIL bad_start_flag sop_err=%b beats=%0d required 1 1", sop_err, out_beats);
    end
    add_packet(1, 2, 8'h70);
    run(50, "bad_start_sticky");
    tests++;
    if (sop_err !== 1'b1) begin
      fails++;
      $display("FAIL bad_start_sticky sop_err=%b required 1", sop_err);
    end
  endtask

  task automatic test_reset_mid_packet();
    int n;
    do_reset();
    add_packet(2, 1, 8'h20);
    run(50, "reset_mid_pre");
    add_packet(1, 5, 8'h30);
    n = 0;
    while (out_beats < 3 && n < 50) begin
      step();
      n++;
    end
    tests++;
    if (out_beats != 3) begin
      fails++;
      $display("FAIL reset_mid_progress beats=%0d required 3", out_beats);
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== '0) begin
      fails++;
      $display("FAIL reset_mid_async out_valid=%b in_ready=%b required 0 0", out_valid, in_ready);
    end
    clear_model();
    reset_release();
    add_packet(3, 2, 8'h40);
    add_packet(1, 2, 8'h50);
    run(50, "reset_mid_post");
    check_order("reset_mid_post", '{1, 3});
    tests++;
    if (sop_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_err sop_err=%b required 0", sop_err);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    add_packet(2, 2, 8'h80);
    run(50, "wrap_pre");
    add_packet(3, 2, 8'h90);
    add_packet(0, 2, 8'hA0);
    run(50, "wrap");
    check_order("wrap", '{2, 3, 0});
  endtask

  task automatic test_random();
    int npkt;
    do_reset();
    vprob = 60;
    rprob = 70;
    npkt  = 40;
    for (int p = 0; p < npkt; p++) begin
      int i;
      i = int'($urandom_range(N - 1));
      if ($urandom_range(5) == 0) add_stray(i, 8'($urandom), 1'($urandom));
      add_packet(i, int'($urandom_range(1, 5)), 8'($urandom));
    end
    run(4000, "random");
    tests++;
    if (pkt_order.size() != npkt || sop_err !== exp_sop_err) begin
      fails++;
      $display("FAIL random_summary packets=%0d sop_err=%b required %0d %b",
               pkt_order.size(), sop_err, npkt, exp_sop_err);
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset_n = 1'b0;
    vprob   = 100;
    rprob   = 100;
    out_ready = 1'b1;
    clear_model();
    test_reset();
    test_single();
    test_fairness();
    test_back_to_back_backpressure();
    test_mid_sop();
    test_bad_start();
    test_reset_mid_packet();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
